// File: rtl/ps2_grid_pkg.sv
// Shared scan codes, move direction encoding and decoder states for the PS/2 grid mover.
package ps2_grid_pkg;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_t;

  typedef struct packed {
    logic hit;
    dir_t dir;
  } key_t;

  function automatic key_t arrow_key(input logic [7:0] code);
    key_t k;
    k.hit = 1'b1;
    k.dir = DIR_UP;
    case (code)
      SC_UP:    k.dir = DIR_UP;
      SC_DOWN:  k.dir = DIR_DOWN;
      SC_LEFT:  k.dir = DIR_LEFT;
      SC_RIGHT: k.dir = DIR_RIGHT;
      default:  k.hit = 1'b0;
    endcase
    return k;
  endfunction

  function automatic key_t wasd_key(input logic [7:0] code);
    key_t k;
    k.hit = 1'b1;
    k.dir = DIR_UP;
    case (code)
      SC_W:    k.dir = DIR_UP;
      SC_S:    k.dir = DIR_DOWN;
      SC_A:    k.dir = DIR_LEFT;
      SC_D:    k.dir = DIR_RIGHT;
      default: k.hit = 1'b0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronisers, tick-sampled shift/count, parity and timeout.
// code_valid/frame_err are registered one CLK after the stop-bit tick; no backpressure.
module ps2_rx_frame
  import ps2_grid_pkg::*;
#(
  parameter int CLK_DIV = 250,
  parameter int TIMEOUT = 4000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       frame_err
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             clk_prev;
  logic             fall;
  logic [3:0]       bit_cnt;
  logic [9:0]       shreg;
  logic [TO_W-1:0]  to_cnt;

  // Idle-high lines, so the synchronisers reset to 1 and no edge is seen on release.
  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST || tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + 1'b1;
  end

  assign fall = tick && clk_prev && !clk_sync[1];

  // shreg holds bits 0..9 (start, data, parity); the stop bit is checked live.
  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_prev   <= 1'b1;
      bit_cnt    <= '0;
      shreg      <= '0;
      to_cnt     <= '0;
      code_valid <= 1'b0;
      code       <= '0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (tick) begin
        clk_prev <= clk_sync[1];
        if (fall) begin
          to_cnt <= '0;
          if (bit_cnt == 4'(FRAME_BITS - 1)) begin
            bit_cnt <= '0;
            if (!shreg[0] && data_sync[1] && (^shreg[9:1])) begin
              code_valid <= 1'b1;
              code       <= shreg[8:1];
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            shreg   <= {data_sync[1], shreg[9:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end else if (bit_cnt != '0) begin
          if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            bit_cnt   <= '0;
            to_cnt    <= '0;
            frame_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end else begin
          to_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_grid_mover.sv
// PS/2 arrow-key decoder with repeat suppression driving a bounded grid position; pos/hop
// change 2 CLK after the stop-bit tick, no backpressure. Define PS2_WASD_EN to add WASD keys.
module ps2_grid_mover
  import ps2_grid_pkg::*;
#(
  parameter int CLK_DIV = 250,
  parameter int TIMEOUT = 4000,
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int X_STEP  = 15,
  parameter int Y_STEP  = 20,
  parameter int X_MIN   = 15,
  parameter int X_MAX   = 300,
  parameter int Y_MIN   = 10,
  parameter int Y_MAX   = 220,
  parameter int X_INIT  = 150,
  parameter int Y_INIT  = 224
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           PS2_CLK,
  input  logic           PS2_DATA,
  input  logic [X_W-1:0] offset_x,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           hop,
  output logic [1:0]     hop_dir,
  output logic           frame_err
);

  logic       code_valid;
  logic [7:0] code;
  logic       rx_err;

  ps2_rx_frame #(
    .CLK_DIV (CLK_DIV),
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .CLK        (CLK),
    .RST        (RST),
    .ps2_clk    (PS2_CLK),
    .ps2_data   (PS2_DATA),
    .code_valid (code_valid),
    .code       (code),
    .frame_err  (rx_err)
  );

  assign frame_err = rx_err;

  dec_state_t state, state_nxt;
  logic [3:0] held, held_nxt;
  logic       move_req, move_req_nxt;
  dir_t       move_dir, move_dir_nxt;
  key_t       akey;
`ifdef PS2_WASD_EN
  logic [3:0] wheld, wheld_nxt;
  key_t       wkey;
`endif

  always_comb begin
    state_nxt    = state;
    held_nxt     = held;
    move_req_nxt = 1'b0;
    move_dir_nxt = move_dir;
    akey         = arrow_key(code);
`ifdef PS2_WASD_EN
    wheld_nxt    = wheld;
    wkey         = wasd_key(code);
`endif
    if (rx_err) begin
      state_nxt = DEC_IDLE;
    end else if (code_valid) begin
      case (state)
        DEC_IDLE: begin
          if (code == SC_EXT)      state_nxt = DEC_EXT;
          else if (code == SC_BRK) state_nxt = DEC_BRK;
`ifdef PS2_WASD_EN
          else if (wkey.hit && !wheld[wkey.dir]) begin
            wheld_nxt[wkey.dir] = 1'b1;
            move_req_nxt        = 1'b1;
            move_dir_nxt        = wkey.dir;
          end
`endif
        end
        DEC_EXT: begin
          if (code == SC_BRK) begin
            state_nxt = DEC_EXT_BRK;
          end else begin
            state_nxt = DEC_IDLE;
            // A held key's typematic repeat is swallowed here.
            if (akey.hit && !held[akey.dir]) begin
              held_nxt[akey.dir] = 1'b1;
              move_req_nxt       = 1'b1;
              move_dir_nxt       = akey.dir;
            end
          end
        end
        DEC_BRK: begin
          state_nxt = DEC_IDLE;
`ifdef PS2_WASD_EN
          if (wkey.hit) wheld_nxt[wkey.dir] = 1'b0;
`endif
        end
        DEC_EXT_BRK: begin
          state_nxt = DEC_IDLE;
          if (akey.hit) held_nxt[akey.dir] = 1'b0;
        end
        default: state_nxt = DEC_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= DEC_IDLE;
      held     <= '0;
      move_req <= 1'b0;
      move_dir <= DIR_UP;
`ifdef PS2_WASD_EN
      wheld    <= '0;
`endif
    end else begin
      state    <= state_nxt;
      held     <= held_nxt;
      move_req <= move_req_nxt;
      move_dir <= move_dir_nxt;
`ifdef PS2_WASD_EN
      wheld    <= wheld_nxt;
`endif
    end
  end

  logic [X_W:0]   eff_x;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;
  logic           move_ok;
  logic [X_W-1:0] x_new;
  logic [Y_W-1:0] y_new;

  assign eff_x = {1'b0, pos_x} + {1'b0, offset_x};
  assign sum_x = {1'b0, pos_x} + (X_W+1)'(X_STEP);
  assign sum_y = {1'b0, pos_y} + (Y_W+1)'(Y_STEP);

  always_comb begin
    move_ok = 1'b0;
    x_new   = pos_x;
    y_new   = pos_y;
    case (move_dir)
      DIR_UP: if (pos_y > Y_W'(Y_MIN) && pos_y >= Y_W'(Y_STEP)) begin
        move_ok = 1'b1;
        y_new   = pos_y - Y_W'(Y_STEP);
      end
      DIR_DOWN: if (pos_y < Y_W'(Y_MAX)) begin
        move_ok = 1'b1;
        y_new   = sum_y[Y_W] ? '1 : sum_y[Y_W-1:0];
      end
      DIR_LEFT: if (eff_x > (X_W+1)'(X_MIN) && pos_x >= X_W'(X_STEP)) begin
        move_ok = 1'b1;
        x_new   = pos_x - X_W'(X_STEP);
      end
      DIR_RIGHT: if (eff_x < (X_W+1)'(X_MAX)) begin
        move_ok = 1'b1;
        x_new   = sum_x[X_W] ? '1 : sum_x[X_W-1:0];
      end
      default: move_ok = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pos_x   <= X_W'(X_INIT);
      pos_y   <= Y_W'(Y_INIT);
      hop     <= 1'b0;
      hop_dir <= 2'd0;
    end else begin
      hop <= move_req && move_ok;
      if (move_req && move_ok) begin
        pos_x   <= x_new;
        pos_y   <= y_new;
        hop_dir <= move_dir;
      end
    end
  end

endmodule

// File: tb/tb_ps2_grid_mover.sv
// Randomised PS/2 key stream against a keystroke-level model of the grid mover.
module tb_ps2_grid_mover;

  localparam int CLK_DIV = 4;
  localparam int TIMEOUT = 40;
  localparam int X_W = 9, Y_W = 8;
  localparam int X_STEP = 15, Y_STEP = 20;
  localparam int X_MIN = 15, X_MAX = 300, Y_MIN = 10, Y_MAX = 220;
  localparam int X_INIT = 150, Y_INIT = 224;
  localparam int HALF = 3 * CLK_DIV;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           PS2_CLK = 1'b1;
  logic           PS2_DATA = 1'b1;
  logic [X_W-1:0] offset_x = '0;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
  logic           hop;
  logic [1:0]     hop_dir;
  logic           frame_err;

  always #5 CLK = ~CLK;

  ps2_grid_mover #(
    .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT), .X_W(X_W), .Y_W(Y_W),
    .X_STEP(X_STEP), .Y_STEP(Y_STEP), .X_MIN(X_MIN), .X_MAX(X_MAX),
    .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT)
  ) dut (
    .CLK(CLK), .RST(RST), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .offset_x(offset_x), .pos_x(pos_x), .pos_y(pos_y), .hop(hop),
    .hop_dir(hop_dir), .frame_err(frame_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: committed state (m_*) and the state expected after the frame in flight (nx_*).
  int m_x, m_y, m_dir, nx_x, nx_y, nx_dir;
  bit m_e0, m_f0, nx_e0, nx_f0;
  bit m_held[4], nx_held[4], m_wheld[4], nx_wheld[4];
  int exp_hop, exp_err;

  bit mon_en = 0, busy = 0, in_rst = 1;
  int hop_cnt = 0, err_cnt = 0, cyc = 0, edge_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int key_dir(input logic [7:0] c, input bit wasd);
    if (!wasd) begin
      case (c)
        8'h75: return 0;
        8'h72: return 1;
        8'h6B: return 2;
        8'h74: return 3;
        default: return -1;
      endcase
    end
    case (c)
      8'h1D: return 0;
      8'h1B: return 1;
      8'h1C: return 2;
      8'h23: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_x = X_INIT; m_y = Y_INIT; m_dir = 0; m_e0 = 0; m_f0 = 0;
    for (int i = 0; i < 4; i++) begin m_held[i] = 0; m_wheld[i] = 0; end
  endtask

  task automatic try_move(input int d);
    int eff;
    bit ok;
    eff = nx_x + int'(offset_x);
    ok = 0;
    case (d)
      0: if (nx_y > Y_MIN && nx_y >= Y_STEP) begin nx_y = nx_y - Y_STEP; ok = 1; end
      1: if (nx_y < Y_MAX) begin
           nx_y = (nx_y + Y_STEP > (1 << Y_W) - 1) ? (1 << Y_W) - 1 : nx_y + Y_STEP; ok = 1;
         end
      2: if (eff > X_MIN && nx_x >= X_STEP) begin nx_x = nx_x - X_STEP; ok = 1; end
      default: if (eff < X_MAX) begin
           nx_x = (nx_x + X_STEP > (1 << X_W) - 1) ? (1 << X_W) - 1 : nx_x + X_STEP; ok = 1;
         end
    endcase
    if (ok) begin nx_dir = d; exp_hop = 1; end
  endtask

  task automatic predict(input logic [7:0] code, input bit good);
    int d;
    nx_x = m_x; nx_y = m_y; nx_dir = m_dir; nx_e0 = m_e0; nx_f0 = m_f0;
    nx_held = m_held; nx_wheld = m_wheld;
    exp_hop = 0;
    exp_err = good ? 0 : 1;
    if (!good) begin
      nx_e0 = 0; nx_f0 = 0;
    end else if (!m_e0 && !m_f0) begin
      if (code == 8'hE0) nx_e0 = 1;
      else if (code == 8'hF0) nx_f0 = 1;
`ifdef PS2_WASD_EN
      else begin
        d = key_dir(code, 1);
        if (d >= 0 && !nx_wheld[d]) begin nx_wheld[d] = 1; try_move(d); end
      end
`endif
    end else if (m_e0 && !m_f0) begin
      if (code == 8'hF0) nx_f0 = 1;
      else begin
        nx_e0 = 0;
        d = key_dir(code, 0);
        if (d >= 0 && !nx_held[d]) begin nx_held[d] = 1; try_move(d); end
      end
    end else begin
      d = key_dir(code, !m_e0);
      if (d >= 0) begin
        if (m_e0) nx_held[d] = 0;
`ifdef PS2_WASD_EN
        else nx_wheld[d] = 0;
`endif
      end
      nx_e0 = 0; nx_f0 = 0;
    end
  endtask

  task automatic finish_window();
    check("hop_count", hop_cnt, exp_hop);
    check("frame_err_count", err_cnt, exp_err);
    m_x = nx_x; m_y = nx_y; m_dir = nx_dir; m_e0 = nx_e0; m_f0 = nx_f0;
    m_held = nx_held; m_wheld = nx_wheld;
    busy = 0;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop bit
  task automatic send_frame(input logic [7:0] code, input int kind);
    logic [10:0] f;
    f = {1'b1, ~^code, code, 1'b0};
    if (kind == 1) f[9] = ~f[9];
    if (kind == 2) f[10] = 1'b0;
    predict(code, kind == 0);
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      PS2_DATA = f[i];
      PS2_CLK = 1'b1;
      repeat (HALF) @(negedge CLK);
      if (i == 10) begin hop_cnt = 0; err_cnt = 0; edge_cyc = cyc; busy = 1; end
      PS2_CLK = 1'b0;
      repeat (HALF) @(negedge CLK);
    end
    PS2_CLK = 1'b1;
    PS2_DATA = 1'b1;
    repeat (2 * HALF) @(negedge CLK);
    finish_window();
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      PS2_DATA = 1'b0;
      PS2_CLK = 1'b1;
      repeat (HALF) @(negedge CLK);
      PS2_CLK = 1'b0;
      repeat (HALF) @(negedge CLK);
    end
    PS2_CLK = 1'b1;
    PS2_DATA = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    in_rst = 1;
    RST = 1'b1;
    @(negedge CLK);
    check("rst_pos_x", int'(pos_x), 150);
    check("rst_pos_y", int'(pos_y), 224);
    check("rst_hop", int'(hop), 0);
    check("rst_hop_dir", int'(hop_dir), 0);
    check("rst_frame_err", int'(frame_err), 0);
    RST = 1'b0;
    model_reset();
    in_rst = 0;
  endtask

  always begin
    int lat;
    @(posedge CLK);
    #2;
    if (mon_en && !in_rst) begin
      if (busy) begin
        if (hop) begin
          hop_cnt++;
          lat = cyc - edge_cyc;
          checks++;
          if (lat < 5 || lat > CLK_DIV + 4) begin
            failures++;
            $display("FAIL hop_latency: got %0d cycles after stop edge, required 5..%0d", lat, CLK_DIV + 4);
          end
        end
        if (frame_err) err_cnt++;
        if (hop_cnt > 0) begin
          check("pos_x_new", int'(pos_x), nx_x);
          check("pos_y_new", int'(pos_y), nx_y);
          check("hop_dir_new", int'(hop_dir), nx_dir);
        end else begin
          check("pos_x_old", int'(pos_x), m_x);
          check("pos_y_old", int'(pos_y), m_y);
          check("hop_dir_old", int'(hop_dir), m_dir);
        end
      end else begin
        check("hop_idle", int'(hop), 0);
        check("frame_err_idle", int'(frame_err), 0);
        check("pos_x", int'(pos_x), m_x);
        check("pos_y", int'(pos_y), m_y);
        check("hop_dir", int'(hop_dir), m_dir);
      end
    end
  end

  task automatic key_make(input logic [7:0] c);
    send_frame(8'hE0, 0);
    send_frame(c, 0);
  endtask

  task automatic key_break(input logic [7:0] c);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(c, 0);
  endtask

  logic [7:0] codes [13] = '{8'hE0, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h75, 8'h72,
                             8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    int pick, kind;
    logic [7:0] c;
    repeat (5) @(negedge CLK);
    check("init_pos_x", int'(pos_x), 150);
    check("init_pos_y", int'(pos_y), 224);
    check("init_hop", int'(hop), 0);
    check("init_hop_dir", int'(hop_dir), 0);
    check("init_frame_err", int'(frame_err), 0);
    RST = 1'b0;
    model_reset();
    in_rst = 0;
    mon_en = 1;

    key_make(8'h72);
    check("down_blocked_y", int'(pos_y), 224);
    key_break(8'h72);

    key_make(8'h75);
    check("up_y", int'(pos_y), 204);
    check("up_dir", int'(hop_dir), 0);
    key_make(8'h75);
    key_make(8'h75);
    check("repeat_y", int'(pos_y), 204);
    key_break(8'h75);
    key_make(8'h75);
    check("second_up_y", int'(pos_y), 184);

    send_bits(3);
    do_reset();
    key_make(8'h75);
    check("after_rst_up_y", int'(pos_y), 204);
    key_break(8'h75);

    send_frame(8'hE0, 0);
    send_frame(8'h75, 1);
    key_make(8'h6B);
    check("left_x", int'(pos_x), 135);
    check("left_dir", int'(hop_dir), 2);
    key_break(8'h6B);
    key_make(8'h74);
    check("right_x", int'(pos_x), 150);
    check("right_dir", int'(hop_dir), 3);
    key_break(8'h74);

    @(negedge CLK) offset_x = 9'd140;
    key_make(8'h74);
    check("carried_right_x", int'(pos_x), 165);
    key_break(8'h74);
    key_make(8'h74);
    check("carried_blocked_x", int'(pos_x), 165);
    key_break(8'h74);
    @(negedge CLK) offset_x = '0;

    send_frame(8'h74, 2);

    send_bits(5);
    predict(8'h00, 0);
    hop_cnt = 0; err_cnt = 0; busy = 1;
    repeat ((TIMEOUT + 6) * CLK_DIV) @(negedge CLK);
    finish_window();
    key_make(8'h6B);
    check("post_timeout_x", int'(pos_x), 150);
    key_break(8'h6B);

    send_frame(8'h1C, 0);
`ifdef PS2_WASD_EN
    check("wasd_left_x", int'(pos_x), 135);
`else
    check("wasd_off_x", int'(pos_x), 150);
`endif
    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);

    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(7) == 0) begin
        @(negedge CLK);
        offset_x = ($urandom_range(3) == 0) ? '0 : X_W'($urandom_range(160));
      end
      pick = int'($urandom_range(13));
      c = (pick == 13) ? 8'($urandom_range(255)) : codes[pick];
      kind = int'($urandom_range(15));
      send_frame(c, (kind == 0) ? 1 : (kind == 1) ? 2 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
